// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: four byte-wide fetch cycles, decode, then a
// short per-opcode execute/writeback tail. All datapath controls are decoded
// combinationally from the current state, the instruction and the zero flag.
module mips_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [2:0]  alucontrol,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic        iord,
    output logic [3:0]  irwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        pcen,
    output logic [1:0]  pcsource,
    output logic        regdst,
    output logic        regwrite,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] funct_alu;
    logic       pcwrite;
    logic       branch;
    logic       unused_instr_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    // Only opcode and funct fields steer control; the rest belongs to the datapath.
    assign unused_instr_bits = ^instr[25:6];

    // State register; reset forces FETCH1 asynchronously so a partially
    // executed instruction is dropped without any further write pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; unknown opcodes fall straight back to fetch.
    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = FETCH4;
            FETCH4: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR:  state_d = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH1;
        endcase
    end

    // R-type ALU operation from the funct field; unlisted functs add.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    // Per-state control outputs; anything not named in a state stays 0 (ALU adds).
    always_comb begin
        alucontrol = ALU_ADD;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        pcsource   = 2'b00;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                irwrite = 4'b0001 << state_q[1:0];
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsource   = 2'b01;
                branch     = 1'b1;
            end
            JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
            end
            ADDIWR: begin
                regwrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Branch resolves in the same cycle the ALU reports zero.
    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: directed scenarios followed by random instruction
// streams, each cycle compared against a per-instruction schedule model.
module tb_mips_controller;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  alucontrol;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        iord;
    logic [3:0]  irwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        pcen;
    logic [1:0]  pcsource;
    logic        regdst;
    logic        regwrite;
    logic [3:0]  state;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    mips_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
        .iord(iord), .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .pcen(pcen), .pcsource(pcsource),
        .regdst(regdst), .regwrite(regwrite), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [18:0] dut_vec;
    assign dut_vec = {alucontrol, alusrca, alusrcb, iord, irwrite, memread,
                      memwrite, memtoreg, pcen, pcsource, regdst, regwrite};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle-by-cycle state schedule of one instruction, by opcode.
    function automatic int build_seq(input logic [5:0] op, output int seq[8]);
        int n;
        for (int i = 0; i < 8; i++) seq[i] = 0;
        for (int i = 0; i < 5; i++) seq[i] = i;
        n = 5;
        case (op)
            6'b100000: begin seq[5] = 5; seq[6] = 6; seq[7] = 7; n = 8; end
            6'b101000: begin seq[5] = 5; seq[6] = 8; n = 7; end
            6'b000000: begin seq[5] = 9; seq[6] = 10; n = 7; end
            6'b000100: begin seq[5] = 11; n = 6; end
            6'b000010: begin seq[5] = 12; n = 6; end
            6'b001000: begin seq[5] = 13; seq[6] = 14; n = 7; end
            default:   n = 5;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] rtype_op(input logic [5:0] f);
        case (f)
            6'd32:   return 3'd2;
            6'd34:   return 3'd6;
            6'd36:   return 3'd0;
            6'd37:   return 3'd1;
            6'd42:   return 3'd7;
            default: return 3'd2;
        endcase
    endfunction

    // Expected control word for a named state, built from the per-state action list.
    function automatic logic [18:0] exp_out(input int st, input logic [31:0] ins, input logic z);
        logic [2:0] ac;
        logic       asa, ior, mr, mw, m2r, pcw, br, rd, rw;
        logic [1:0] asb, ps;
        logic [3:0] irw;
        ac = 3'd2; asa = 0; asb = 0; ior = 0; irw = 0; mr = 0; mw = 0;
        m2r = 0; pcw = 0; br = 0; ps = 0; rd = 0; rw = 0;
        if (st <= 3) begin
            mr = 1; asb = 2'd1; pcw = 1;
            irw = 4'(1 << st);
        end else begin
            case (st)
                4:  asb = 2'd3;
                5, 13: begin asa = 1; asb = 2'd2; end
                6:  begin mr = 1; ior = 1; end
                7:  begin rw = 1; m2r = 1; end
                8:  begin mw = 1; ior = 1; end
                9:  begin asa = 1; ac = rtype_op(ins[5:0]); end
                10: begin rd = 1; rw = 1; end
                11: begin asa = 1; ac = 3'd6; ps = 2'd1; br = 1; end
                12: begin ps = 2'd2; pcw = 1; end
                14: rw = 1;
                default: ;
            endcase
        end
        return {ac, asa, asb, ior, irw, mr, mw, m2r, pcw | (br & z), ps, rd, rw};
    endfunction

    // Runs cycles [first, stop) of an instruction (stop<0 means to completion),
    // starting at posedge+1 and leaving at posedge+1 of the following cycle.
    // zmode: 0 -> zero low, 1 -> zero high, 2 -> random each cycle.
    task automatic run_instr(input logic [31:0] ins, input int zmode, input int first, input int stop);
        int seq[8];
        int n, lim;
        n = build_seq(ins[31:26], seq);
        lim = (stop >= 0 && stop < n) ? stop : n;
        for (int c = first; c < lim; c++) begin
            instr = ins;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #2;
            check($sformatf("state op=%b c=%0d", ins[31:26], c), 32'(state), 32'(seq[c]));
            check($sformatf("ctrl op=%b f=%b c=%0d z=%0b", ins[31:26], ins[5:0], c, zero),
                  32'(dut_vec), 32'(exp_out(seq[c], ins, zero)));
            @(posedge clk); #1;
        end
        if (lim == n) begin
            #1;
            check($sformatf("return op=%b", ins[31:26]), 32'(state), 32'd0);
            #1;
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] f);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        r[5:0] = f;
        return r;
    endfunction

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        logic [5:0] op;
        logic [5:0] fn;
        ops[0] = 6'b100000; ops[1] = 6'b101000; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
        fns[3] = 6'b100101; fns[4] = 6'b101010;

        // Reset held low before any clock edge: FETCH1 outputs immediately.
        reset = 1'b0;
        instr = 32'h0;
        zero  = 1'b0;
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset irwrite", 32'(irwrite), 32'b0001);
        check("reset memread", 32'(memread), 32'd1);
        check("reset alusrcb", 32'(alusrcb), 32'b01);
        check("reset pcen", 32'(pcen), 32'd1);
        check("reset memwrite", 32'(memwrite), 32'd0);
        check("reset regwrite", 32'(regwrite), 32'd0);
        @(posedge clk); #1;
        check("reset held over edge", 32'(state), 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        check("first edge after release", 32'(state), 32'd1);
        run_instr(mk(6'b001000, 6'd0), 0, 1, -1);

        // Directed: ADDI, BEQ taken / not taken, R-type slt/sub, J, illegal, LB then SB.
        run_instr(mk(6'b001000, 6'd5), 0, 0, -1);
        run_instr(mk(6'b000100, 6'd0), 1, 0, -1);
        run_instr(mk(6'b000100, 6'd0), 0, 0, -1);
        run_instr(mk(6'b000000, 6'b101010), 0, 0, -1);
        run_instr(mk(6'b000000, 6'b100010), 0, 0, -1);
        run_instr(mk(6'b000000, 6'b111111), 0, 0, -1);
        run_instr(mk(6'b000010, 6'd0), 0, 0, -1);
        run_instr(mk(6'b111111, 6'd0), 2, 0, -1);
        run_instr(mk(6'b100000, 6'd0), 0, 0, -1);
        run_instr(mk(6'b101000, 6'd0), 0, 0, -1);

        // Reset during LBRD: instruction is dropped, no LBWR write occurs.
        instr = mk(6'b100000, 6'd0);
        run_instr(instr, 0, 0, 6);
        #2;
        check("in LBRD before reset", 32'(state), 32'd6);
        reset = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset irwrite", 32'(irwrite), 32'b0001);
        check("async reset regwrite", 32'(regwrite), 32'd0);
        check("async reset memwrite", 32'(memwrite), 32'd0);
        @(posedge clk); #1;
        check("no LBWR regwrite under reset", 32'(regwrite), 32'd0);
        check("state held under reset", 32'(state), 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        check("resume after reset", 32'(state), 32'd1);
        run_instr(instr, 0, 1, -1);

        // Random instruction stream with random zero each cycle.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 6) == 6) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = fns[$urandom_range(0, 4)];
            run_instr(mk(op, fn), 2, 0, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001: The block SHALL have one clock, `clk`; all state SHALL update on its rising edge.
REQ-002: The block SHALL have one reset, `reset`, which is asynchronous and active-low.
REQ-003: Ports SHALL be, as name / direction / width / meaning:
- clk / in / 1 / clock.
- reset / in / 1 / async active-low reset.
- instr / in / 32 / current instruction; op = instr[31:26], funct = instr[5:0].
- zero / in / 1 / ALU-result-is-zero flag.
- alucontrol / out / 3 / ALU operation.
- alusrca / out / 1 / 0 = PC, 1 = register A.
- alusrcb / out / 2 / 00 = B, 01 = constant 1, 10 = instr[7:0], 11 = constx4.
- iord / out / 1 / 0 = PC address, 1 = aluout address.
- irwrite / out / 4 / byte enables; bit0 loads instr[31:24], bit3 loads instr[7:0].
- memread / out / 1 / memory read strobe.
- memwrite / out / 1 / memory write strobe.
- memtoreg / out / 1 / 0 = aluout, 1 = memory data to register write data.
- pcen / out / 1 / PC load enable.
- pcsource / out / 2 / 00 = aluresult, 01 = aluout, 10 = constx4, 11 = reserved.
- regdst / out / 1 / 0 = instr[18:16], 1 = instr[13:11].
- regwrite / out / 1 / register file write enable.
- state / out / 4 / current FSM state encoding, for debug.

Function
REQ-004: The block SHALL be a multicycle FSM with these states and encodings: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14.
REQ-005: Opcodes SHALL be LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-006: State transitions SHALL be:
- FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
- DECODE -> MEMADR (LB or SB), RTYPEEX, BEQEX, JEX or ADDIEX by op; any other op -> FETCH1.
- MEMADR -> LBRD (LB) or SBWR (SB).
- LBRD -> LBWR.
- RTYPEEX -> RTYPEWR.
- ADDIEX -> ADDIWR.
- LBWR, SBWR, RTYPEWR, BEQEX, JEX and ADDIWR -> FETCH1.
REQ-007: Any output not driven in a state SHALL be 0, except alucontrol, which SHALL default to 010 (add).
REQ-008: FETCHn (n=1..4) SHALL drive: memread=1, iord=0, irwrite=one-hot bit n-1, alusrca=0, alusrcb=01, pcsource=00, pcwrite=1.
REQ-009: DECODE SHALL drive alusrca=0, alusrcb=11 (branch target into aluout).
REQ-010: MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10.
REQ-011: LBRD SHALL drive memread=1, iord=1.
REQ-012: LBWR SHALL drive regwrite=1, memtoreg=1, regdst=0.
REQ-013: SBWR SHALL drive memwrite=1, iord=1.
REQ-014: RTYPEEX SHALL drive alusrca=1, alusrcb=00, and alucontrol decoded from funct.
REQ-015: RTYPEWR SHALL drive regdst=1, memtoreg=0, regwrite=1.
REQ-016: ADDIWR SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-017: BEQEX SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsource=01, branch=1.
REQ-018: JEX SHALL drive pcsource=10, pcwrite=1.
REQ-019: pcen SHALL equal pcwrite OR (branch AND zero), evaluated combinationally in the same cycle as zero.
REQ-020: In RTYPEEX, alucontrol SHALL decode funct as: 100000 -> 010 add, 100010 -> 110 sub, 100100 -> 000 and, 100101 -> 001 or, 101010 -> 111 slt; any other funct -> 010.
REQ-021: Every instruction SHALL take a fixed number of cycles, counting four fetch cycles plus DECODE:
- LB: 8.
- SB, R-type, ADDI: 7.
- BEQ, J: 6.
- Illegal op: 5.
REQ-022: All outputs other than state SHALL be decoded from state, instr and zero only, with no added pipeline latency.

Reset
REQ-023: While reset=0, state SHALL be FETCH1 immediately, regardless of clk.
REQ-024: While reset=0, the outputs SHALL be FETCH1 values: memread=1, irwrite=0001, alusrcb=01, pcen=1.
REQ-025: Reset asserted mid-instruction SHALL abandon that instruction; no further regwrite or memwrite pulse for it SHALL occur.
REQ-026: After reset releases, the first rising clk edge SHALL advance the FSM FETCH1 -> FETCH2.

Verification
REQ-027: Reset: assert reset=0 between clock edges -> state=0 at once, irwrite=0001, memwrite=0, regwrite=0.
REQ-028: ADDI (op=001000) -> state sequence 0,1,2,3,4,13,14,0; regwrite=1 only in cycle 7, with regdst=0.
REQ-029: BEQ with zero=1 in BEQEX -> pcen=1 and pcsource=01 in state 11. Same instruction with zero=0 -> pcen=0. Both cases return to state 0.
REQ-030: R-type with funct=101010 -> alucontrol=111 in RTYPEEX. R-type with funct=100010 -> alucontrol=110.
REQ-031: Illegal op=111111 -> DECODE returns to FETCH1 with no regwrite, memwrite or extra pcen.
REQ-032: LB followed by SB -> memread=1 in LBRD, then memwrite=1 only in SBWR. Reset=0 applied during LBRD -> no LBWR regwrite occurs.
